// File: rtl/gray_pkg.sv
// Shared types and helpers for the sequential Gray-to-binary decoder.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_MIN = 2;
  localparam int unsigned GRAY_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reference decode of the low w bits of g; upper bits of the result are zero.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
    input logic [GRAY_WIDTH_MAX-1:0] g,
    input int unsigned               w
  );
    logic [GRAY_WIDTH_MAX-1:0] b;
    logic                      acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_WIDTH_MAX - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_check.sv
// Flags a decoded word that is neither a repeat nor a +1 step (mod 2^WIDTH) of prev.
module gray_step_check
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic             has_prev_i,
  output logic             step_err_c
);

  logic [WIDTH-1:0] diff_c;

  // Modular difference makes the all-ones -> zero wrap a legal +1 step.
  always_comb begin
    diff_c     = bin_i - prev_i;
    step_err_c = has_prev_i && (diff_c != WIDTH'(0)) && (diff_c != WIDTH'(1));
  end

endmodule

// File: rtl/gray_to_bin_seq.sv
// Bit-serial Gray-to-binary decoder, MSB first, with valid/ready ports and
// a step-legality check against the previously delivered word.
module gray_to_bin_seq
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] g_q,         g_d;
  logic [WIDTH-1:0] bin_q,       bin_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             bit_q,       bit_d;
  logic [WIDTH-1:0] prev_q,      prev_d;
  logic             has_prev_q,  has_prev_d;
  logic             err_q,       err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;

  logic             new_bit_c;
  logic [WIDTH-1:0] bin_fin_c;
  logic             step_err_c;

  // bit_q carries b[i+1]; it is zero before the MSB, matching b[WIDTH] = 0.
  always_comb begin
    new_bit_c          = bit_q ^ g_q[idx_q];
    bin_fin_c          = bin_q;
    bin_fin_c[idx_q]   = new_bit_c;
  end

  gray_step_check #(
    .WIDTH (WIDTH)
  ) u_step_check (
    .bin_i      (bin_fin_c),
    .prev_i     (prev_q),
    .has_prev_i (has_prev_q),
    .step_err_c (step_err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      bin_q       <= '0;
      idx_q       <= '0;
      bit_q       <= 1'b0;
      prev_q      <= '0;
      has_prev_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      bin_q       <= bin_d;
      idx_q       <= idx_d;
      bit_q       <= bit_d;
      prev_q      <= prev_d;
      has_prev_q  <= has_prev_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    bin_d      = bin_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          g_d     = in_gray;
          bin_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          bit_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bin_d = bin_fin_c;
        bit_d = new_bit_c;
        if (idx_q == IDX_W'(0)) begin
          err_d   = step_err_c;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          prev_d     = bin_q;
          has_prev_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered copies of the state being entered.
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_bin      = bin_q;
  assign out_step_err = err_q;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed bench for gray_to_bin_seq at WIDTH=4 with hand-computed expectations.
module tb_gray_to_bin_seq;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_step_err;

  int checks = 0;
  int errors = 0;

  gray_to_bin_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_gray      (in_gray),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bin      (out_bin),
    .out_step_err (out_step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Cycles from the acceptance edge until out_valid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic decode(input string tag, input logic [WIDTH-1:0] g,
                        input logic [WIDTH-1:0] exp_bin, input logic exp_err);
    int n;
    wait_ready();
    in_valid = 1'b1;
    in_gray  = g;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk({tag, "_lat"}, 32'(n), 32'(WIDTH));
    chk({tag, "_bin"}, 32'(out_bin), 32'(exp_bin));
    chk({tag, "_err"}, 32'(out_step_err), 32'(exp_err));
    tick();
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  logic [WIDTH-1:0] gray_seq [17] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
    4'b0000
  };

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_gray   = '0;
    out_ready = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_step_err", 32'(out_step_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    decode("single", 4'b0110, 4'b0100, 1'b0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      decode($sformatf("count%0d", i), gray_seq[i], 4'((i % 16)), 1'b0);
    end

    do_reset();
    decode("jump_a", 4'b0000, 4'd0, 1'b0);
    decode("jump_b", 4'b0011, 4'd2, 1'b1);
    decode("jump_rep", 4'b0011, 4'd2, 1'b0);

    // Backpressure: stall DONE while a new word waits on the input.
    do_reset();
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    in_gray  = 4'b0001;
    tick();
    in_gray = 4'b0010;
    wait_out(n);
    chk("bp_lat", 32'(n), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_bin%0d", i), 32'(out_bin), 32'd1);
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_cap_rdy", 32'(in_ready), 32'd0);
    wait_out(n);
    chk("bp2_lat", 32'(n), 32'(WIDTH));
    chk("bp2_bin", 32'(out_bin), 32'd3);
    chk("bp2_err", 32'(out_step_err), 32'd1);
    tick();

    // Reset during BUSY discards the word and clears has_prev.
    do_reset();
    decode("pre_mid", 4'b0110, 4'b0100, 1'b0);
    wait_ready();
    in_valid = 1'b1;
    in_gray  = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bin", 32'(out_bin), 32'd0);
    tick();
    chk("mid_next_rdy", 32'(in_ready), 32'd1);
    chk("mid_next_valid", 32'(out_valid), 32'd0);
    chk("mid_next_bin", 32'(out_bin), 32'd0);
    decode("post_mid", 4'b0001, 4'd1, 1'b0);

    // Reset and in_valid together: nothing captured.
    wait_ready();
    in_valid = 1'b1;
    in_gray  = 4'b0111;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("rst_vs_valid_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      chk($sformatf("rst_vs_valid_no_out%0d", i), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
